// File: rtl/key_debounce_if.sv
// Key debounce interface: scanner-side inputs and committed-key outputs.
// master = scanner/consumer side, slave = debounce stage.
interface key_debounce_if #(
    parameter int KEY_W = 4
);
    logic [KEY_W-1:0] keyDecoded;
    logic             keyPressed;
    logic [KEY_W-1:0] keyDebounced;
    logic             keyValid;
    logic             keyHeld;
    logic             keyReleased;

    modport master (
        output keyDecoded,
        output keyPressed,
        input  keyDebounced,
        input  keyValid,
        input  keyHeld,
        input  keyReleased
    );

    modport slave (
        input  keyDecoded,
        input  keyPressed,
        output keyDebounced,
        output keyValid,
        output keyHeld,
        output keyReleased
    );
endinterface

// File: rtl/key_debounce_fsm.sv
// Key debounce / commit stage between the keypad decoder and the display logic.
// A key code is committed only after PRESS_CYCLES stable pressed samples; the
// release is qualified by RELEASE_CYCLES consecutive released samples.
// Optional typematic repeat: define KEY_DEBOUNCE_AUTO_REPEAT_EN.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | no key down, waiting for keyPressed
//   PRESS_WAIT   | candidate code latched, counting stable pressed samples
//   HELD         | key committed, waiting for keyPressed to drop
//   RELEASE_WAIT | counting released samples; a press returns to HELD
module key_debounce_fsm #(
    parameter int KEY_W          = 4,
    parameter int PRESS_CYCLES   = 240000,
    parameter int RELEASE_CYCLES = 240000,
    parameter int REPEAT_DELAY   = 24000000,
    parameter int REPEAT_PERIOD  = 4800000
) (
    input logic           clk,
    input logic           reset,
    key_debounce_if.slave kif
);

    localparam int MAX_CNT = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    // Catch nonsensical parameterisations at elaboration.
    if (PRESS_CYCLES < 2 || RELEASE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_fsm: illegal count parameters");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             released_q, released_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment so the counter can never wrap.
    assign cnt_inc = (cnt_q == CNT_W'(MAX_CNT)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic [REP_W-1:0] rep_target;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rep_target = rep_first_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_d      = key_q;
        valid_d    = 1'b0;
        held_d     = held_q;
        released_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (kif.keyPressed) begin
                    cand_d  = kif.keyDecoded;
                    cnt_d   = CNT_W'(1);
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!kif.keyPressed) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (kif.keyDecoded != cand_q) begin
                    cand_d = kif.keyDecoded;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == CNT_W'(PRESS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    key_d   = cand_q;
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!kif.keyPressed) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                // Release bounce: the code is deliberately not re-checked.
                if (kif.keyPressed) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                    cnt_d      = '0;
                    held_d     = 1'b0;
                    released_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    // Typematic repeat: restart on every HELD entry, strobe while staying in HELD.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (state_d == HELD && state_q != HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (rep_cnt_q == rep_target) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            key_q      <= key_d;
`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
            valid_q    <= valid_d |
                          ((state_q == HELD) && (state_d == HELD) && (rep_cnt_q == rep_target));
`else
            valid_q    <= valid_d;
`endif
            held_q     <= held_d;
            released_q <= released_d;
        end
    end

    assign kif.keyDebounced = key_q;
    assign kif.keyValid     = valid_q;
    assign kif.keyHeld      = held_q;
    assign kif.keyReleased  = released_q;

endmodule
